// File: rtl/player_combat_ctrl.sv
// Per-player combat controller: button-to-action encoding, attack/cooldown sequencing,
// health tracking and game-over status for one player's sprite block.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | no attack in progress, a fresh press may start one
// ACTIVE   | attack animation running for ATTACK_CYCLES cycles
// COOLDOWN | recovery window of COOLDOWN_CYCLES cycles, presses are dropped
module player_combat_ctrl #(
  parameter int unsigned ATTACK_CYCLES   = 33_300_002,
  parameter int unsigned COOLDOWN_CYCLES = 10_000_000,
  parameter logic [7:0]  MAX_HEALTH      = 8'd100,
  parameter logic [7:0]  HIT_DAMAGE      = 8'd10,
  parameter logic        INIT_DIR        = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_crouch,
  input  logic       btn_attack,
  input  logic       in_range,
  input  logic       opponent_damage,
  input  logic       opponent_dead,
  output logic [6:0] action,
  output logic       attack_grant,
  output logic [7:0] health,
  output logic [1:0] finish
);

  localparam logic [5:0]  ACT_WALK      = 6'b000001;
  localparam logic [5:0]  ACT_CROUCH    = 6'b000010;
  localparam logic [5:0]  ACT_STAND     = 6'b100000;
  localparam logic [25:0] ATTACK_LAST   = 26'(ATTACK_CYCLES - 1);
  localparam logic [25:0] COOLDOWN_LAST = 26'(COOLDOWN_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, COOLDOWN} state_t;

  state_t      state;
  logic [25:0] count;
  logic        attack_prev;
  logic        damage_prev;
  logic        only_left;
  logic        only_right;
  logic        attack_press;
  logic        hit;
  logic [5:0]  next_code;

  assign only_left    = btn_left & ~btn_right;
  assign only_right   = btn_right & ~btn_left;
  assign attack_press = btn_attack & ~attack_prev;
  assign hit          = opponent_damage & ~damage_prev & in_range & ~finish[0];

  always_comb begin
    next_code = ACT_STAND;
    if (btn_crouch)
      next_code = ACT_CROUCH;
    else if (only_left || only_right)
      next_code = ACT_WALK;
  end

  // Action word; once the game is over the sprite stands still and keeps facing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      action <= {INIT_DIR, ACT_STAND};
    end else if (finish[0]) begin
      action[5:0] <= ACT_STAND;
    end else begin
      action[5:0] <= next_code;
      if (only_left)
        action[6] <= 1'b1;
      else if (only_right)
        action[6] <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      attack_prev <= 1'b0;
      damage_prev <= 1'b0;
    end else begin
      attack_prev <= btn_attack;
      damage_prev <= opponent_damage;
    end
  end

  // Attack sequencer; an attack already running finishes even after game over.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      count        <= '0;
      attack_grant <= 1'b0;
    end else begin
      attack_grant <= 1'b0;
      case (state)
        IDLE: begin
          if (attack_press && action[5:0] != ACT_CROUCH && !finish[0]) begin
            attack_grant <= 1'b1;
            state        <= ACTIVE;
            count        <= '0;
          end
        end
        ACTIVE: begin
          if (count == ATTACK_LAST) begin
            state <= COOLDOWN;
            count <= '0;
          end else begin
            count <= count + 26'd1;
          end
        end
        COOLDOWN: begin
          if (count == COOLDOWN_LAST) begin
            state <= IDLE;
            count <= '0;
          end else begin
            count <= count + 26'd1;
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

  // Health and finish; finish trails the killing hit by one cycle and is sticky.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      health <= MAX_HEALTH;
      finish <= 2'b00;
    end else begin
      if (hit)
        health <= (health >= HIT_DAMAGE) ? health - HIT_DAMAGE : 8'd0;
      if (!finish[0]) begin
        if (health == 8'd0)
          finish <= 2'b11;
        else if (opponent_dead)
          finish <= 2'b01;
      end
    end
  end

endmodule

// File: tb/tb_player_combat_ctrl.sv
// Scoreboard bench for player_combat_ctrl with short attack/cooldown timing and low health.
module tb_player_combat_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_left, btn_right, btn_crouch, btn_attack;
  logic       in_range, opponent_damage, opponent_dead;
  logic [6:0] action;
  logic       attack_grant;
  logic [7:0] health;
  logic [1:0] finish;

  int n_checks = 0;
  int n_fail   = 0;
  int grant_cnt = 0;
  int snap;

  string       tag_q[$];
  logic [31:0] exp_q[$];

  player_combat_ctrl #(
    .ATTACK_CYCLES  (8),
    .COOLDOWN_CYCLES(4),
    .MAX_HEALTH     (8'd25),
    .HIT_DAMAGE     (8'd10),
    .INIT_DIR       (1'b0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .btn_left       (btn_left),
    .btn_right      (btn_right),
    .btn_crouch     (btn_crouch),
    .btn_attack     (btn_attack),
    .in_range       (in_range),
    .opponent_damage(opponent_damage),
    .opponent_dead  (opponent_dead),
    .action         (action),
    .attack_grant   (attack_grant),
    .health         (health),
    .finish         (finish)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!rst && attack_grant) grant_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      check(tag_q.pop_front(), obs, exp_q.pop_front());
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    {btn_left, btn_right, btn_crouch, btn_attack} = '0;
    {in_range, opponent_damage, opponent_dead} = '0;
    tick(2);
    sb_push("rst_action", 32'h20); sb_push("rst_grant", 0);
    sb_push("rst_health", 25);     sb_push("rst_finish", 0);
    sb_pop(32'(action)); sb_pop(32'(attack_grant)); sb_pop(32'(health)); sb_pop(32'(finish));
    rst = 1'b0;
    tick();

    // walking right, then release
    btn_right = 1'b1; sb_push("walk_right", 32'h01); tick(); sb_pop(32'(action));
    sb_push("walk_right_hold", 32'h01); tick(4); sb_pop(32'(action));
    btn_right = 1'b0; sb_push("stand_after_right", 32'h20); tick(); sb_pop(32'(action));

    // crouch with left, then both directions
    btn_left = 1'b1; btn_crouch = 1'b1;
    sb_push("crouch_left", 32'h42); tick(); sb_pop(32'(action));
    btn_crouch = 1'b0; btn_right = 1'b1;
    sb_push("both_dirs_stand", 32'h60); tick(); sb_pop(32'(action));
    btn_left = 1'b0; btn_right = 1'b0;
    sb_push("stand_dir_held", 32'h60); tick(); sb_pop(32'(action));

    // attack held: single grant
    snap = grant_cnt;
    btn_attack = 1'b1;
    sb_push("grant_first", 1); tick(); sb_pop(32'(attack_grant));
    sb_push("grant_width", 0); tick(); sb_pop(32'(attack_grant));
    tick(28);
    sb_push("held_single_grant", 32'(snap + 1)); sb_pop(32'(grant_cnt));
    btn_attack = 1'b0; tick();

    // press during cooldown dropped, after window granted
    btn_attack = 1'b1;
    sb_push("grant_second", 1); tick(); sb_pop(32'(attack_grant));
    btn_attack = 1'b0; tick(4);
    btn_attack = 1'b1;
    sb_push("press_at_5_dropped", 0); tick(); sb_pop(32'(attack_grant));
    btn_attack = 1'b0; tick(7);
    btn_attack = 1'b1;
    sb_push("press_at_13_granted", 1); tick(); sb_pop(32'(attack_grant));
    btn_attack = 1'b0; tick(15);

    // damage held high counts once; out of range ignored
    in_range = 1'b1; opponent_damage = 1'b1;
    sb_push("hit_first", 15); tick(); sb_pop(32'(health));
    sb_push("hit_held_once", 15); tick(99); sb_pop(32'(health));
    opponent_damage = 1'b0; tick();
    in_range = 1'b0; opponent_damage = 1'b1;
    sb_push("hit_out_of_range", 15); tick(); sb_pop(32'(health));
    opponent_damage = 1'b0; tick();

    // further hits down to zero with saturation
    in_range = 1'b1; btn_left = 1'b1;
    opponent_damage = 1'b1; sb_push("hit_to_5", 5); tick(); sb_pop(32'(health));
    opponent_damage = 1'b0; tick();
    opponent_damage = 1'b1;
    sb_push("hit_saturate_0", 0); sb_push("finish_lag", 0);
    tick(); sb_pop(32'(health)); sb_pop(32'(finish));
    opponent_damage = 1'b0;
    sb_push("finish_dead", 3); sb_push("action_at_finish", 32'h41);
    tick(); sb_pop(32'(finish)); sb_pop(32'(action));
    btn_attack = 1'b1; btn_left = 1'b0; btn_right = 1'b1;
    sb_push("action_forced_stand", 32'h60); sb_push("no_grant_dead", 0);
    tick(); sb_pop(32'(action)); sb_pop(32'(attack_grant));
    opponent_damage = 1'b1;
    sb_push("no_grant_dead_late", 0); tick(); sb_pop(32'(attack_grant));
    sb_push("finish_sticky", 3); tick(3); sb_pop(32'(finish));

    // reset mid-attack
    rst = 1'b1; tick();
    {btn_left, btn_right, btn_crouch, btn_attack, opponent_damage} = '0;
    rst = 1'b0; tick();
    opponent_damage = 1'b1; sb_push("hit_after_rst", 15); tick(); sb_pop(32'(health));
    opponent_damage = 1'b0;
    btn_attack = 1'b1; sb_push("grant_pre_rst", 1); tick(); sb_pop(32'(attack_grant));
    tick(3);
    rst = 1'b1; #1;
    sb_push("async_rst_health", 25); sb_push("async_rst_finish", 0);
    sb_push("async_rst_grant", 0);   sb_push("async_rst_action", 32'h20);
    sb_pop(32'(health)); sb_pop(32'(finish)); sb_pop(32'(attack_grant)); sb_pop(32'(action));
    btn_attack = 1'b0;
    tick(2);
    rst = 1'b0;
    snap = grant_cnt;
    tick(20);
    sb_push("no_grant_after_rst", 32'(snap)); sb_pop(32'(grant_cnt));

    // opponent dies
    opponent_dead = 1'b1; sb_push("finish_won", 1); tick(); sb_pop(32'(finish));
    opponent_dead = 1'b0; sb_push("finish_won_sticky", 1); tick(3); sb_pop(32'(finish));
    opponent_damage = 1'b1; sb_push("hit_ignored_finished", 25); tick(); sb_pop(32'(health));
    opponent_damage = 1'b0; tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
